// File: rtl/vga_pkg.sv
// Shared VGA compositor types and defaults.
// Colour struct, background colour and flash length.
package vga_pkg;
  localparam int COLOR_W_DEF      = 10;
  localparam int POS_W_DEF        = 10;
  localparam int FLASH_FRAMES_DEF = 8;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  localparam rgb_t BG_DEF = '{r: '0, g: '0, b: '0};
endpackage

// File: rtl/layer_priority_mux.sv
// Combinational fixed-priority layer select.
// Highest enabled+valid index wins.
module layer_priority_mux #(
  parameter int NUM_LAYERS = 12,
  parameter int COLOR_W    = 10,
  localparam int IDX_W     = $clog2(NUM_LAYERS + 1)
) (
  input  logic [NUM_LAYERS-1:0]           i_valid,
  input  logic [NUM_LAYERS-1:0]           i_en,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] i_rgb,
  output logic [IDX_W-1:0]                o_idx,
  output logic [3*COLOR_W-1:0]            o_rgb,
  output logic                            o_hit
);
  // Scan upward so the last (highest) match wins
  always_comb begin
    o_idx = IDX_W'(NUM_LAYERS);
    o_rgb = '0;
    o_hit = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (i_valid[i] && i_en[i]) begin
        o_idx = IDX_W'(i);
        o_rgb = i_rgb[i*3*COLOR_W +: 3*COLOR_W];
        o_hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage layer compositor with hit flash
// and frame-latched game-over mode.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS   = 12,
  parameter int COLOR_W      = COLOR_W_DEF,
  parameter int POS_W        = POS_W_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int BG_R         = int'(BG_DEF.r),
  parameter int BG_G         = int'(BG_DEF.g),
  parameter int BG_B         = int'(BG_DEF.b),
  localparam int IDX_W       = $clog2(NUM_LAYERS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [POS_W-1:0]                px,
  input  logic [POS_W-1:0]                py,
  input  logic [NUM_LAYERS-1:0]           layer_valid,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic                            over_valid,
  input  logic [3*COLOR_W-1:0]            over_rgb,
  input  logic                            game_over,
  input  logic                            hit_pulse,
  output logic [COLOR_W-1:0]              r,
  output logic [COLOR_W-1:0]              g,
  output logic [COLOR_W-1:0]              b,
  output logic [POS_W-1:0]                px_out,
  output logic [POS_W-1:0]                py_out,
  output logic [IDX_W-1:0]                top_layer
);
  localparam int CW3 = 3 * COLOR_W;

  logic               w_origin;
  logic               w_sof;
  logic               r_origin;
  logic               r_mode_go;
  logic [7:0]         r_flash_cnt;
  logic [IDX_W-1:0]   w_mux_idx;
  logic [CW3-1:0]     w_mux_rgb;
  logic               w_mux_hit;
  logic [CW3-1:0]     w_s1_rgb;
  logic [CW3-1:0]     r_s1_rgb;
  logic [IDX_W-1:0]   r_s1_idx;
  logic               r_s1_ov;
  logic [CW3-1:0]     r_s1_orgb;
  logic [POS_W-1:0]   r_s1_px;
  logic [POS_W-1:0]   r_s1_py;
  logic [COLOR_W-1:0] w_r;
  logic [COLOR_W-1:0] w_g;
  logic [COLOR_W-1:0] w_b;
  logic [IDX_W-1:0]   w_top;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_grn;
  logic [COLOR_W-1:0] r_blu;
  logic [POS_W-1:0]   r_px;
  logic [POS_W-1:0]   r_py;
  logic [IDX_W-1:0]   r_top;

  assign w_origin = (px == '0) && (py == '0);
  assign w_sof    = w_origin && !r_origin;

  // Remember origin so a held (0,0) gives one sof
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_origin <= 1'b0;
    else        r_origin <= w_origin;
  end

  // Frame-latched mode and frame-counted flash
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode_go   <= 1'b0;
      r_flash_cnt <= 8'd0;
    end else begin
      if (w_sof) r_mode_go <= game_over;
      if (hit_pulse)
        r_flash_cnt <= 8'(FLASH_FRAMES);
      else if (w_sof && r_flash_cnt != 8'd0)
        r_flash_cnt <= r_flash_cnt - 8'd1;
    end
  end

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W)
  ) u_mux (
    .i_valid (layer_valid),
    .i_en    (layer_en),
    .i_rgb   (layer_rgb),
    .o_idx   (w_mux_idx),
    .o_rgb   (w_mux_rgb),
    .o_hit   (w_mux_hit)
  );

  assign w_s1_rgb = w_mux_hit ? w_mux_rgb
                  : {COLOR_W'(BG_R), COLOR_W'(BG_G),
                     COLOR_W'(BG_B)};

  // Stage 1: capture winner, overlay and position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_rgb  <= '0;
      r_s1_idx  <= '0;
      r_s1_ov   <= 1'b0;
      r_s1_orgb <= '0;
      r_s1_px   <= '0;
      r_s1_py   <= '0;
    end else begin
      r_s1_rgb  <= w_s1_rgb;
      r_s1_idx  <= w_mux_idx;
      r_s1_ov   <= over_valid;
      r_s1_orgb <= over_rgb;
      r_s1_px   <= px;
      r_s1_py   <= py;
    end
  end

  // Stage 2 colour: overlay in game-over, else tint
  always_comb begin
    w_r   = r_s1_rgb[CW3-1 -: COLOR_W];
    w_g   = r_s1_rgb[2*COLOR_W-1 -: COLOR_W];
    w_b   = r_s1_rgb[COLOR_W-1:0];
    w_top = r_s1_idx;
    if (r_mode_go) begin
      w_top = IDX_W'(NUM_LAYERS);
      if (r_s1_ov) begin
        w_r = r_s1_orgb[CW3-1 -: COLOR_W];
        w_g = r_s1_orgb[2*COLOR_W-1 -: COLOR_W];
        w_b = r_s1_orgb[COLOR_W-1:0];
      end else begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
      end
    end else if (r_flash_cnt != 8'd0 && r_flash_cnt[0]) begin
      w_r = '1;
      w_g = w_g >> 1;
      w_b = w_b >> 1;
    end
  end

  // Stage 2: register outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
      r_px  <= '0;
      r_py  <= '0;
      r_top <= '0;
    end else begin
      r_red <= w_r;
      r_grn <= w_g;
      r_blu <= w_b;
      r_px  <= r_s1_px;
      r_py  <= r_s1_py;
      r_top <= w_top;
    end
  end

  assign r         = r_red;
  assign g         = r_grn;
  assign b         = r_blu;
  assign px_out    = r_px;
  assign py_out    = r_py;
  assign top_layer = r_top;
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised scoreboard bench for vga_layer_compositor.
// Reference model follows the frame/flash/mode rules directly.
module tb_vga_layer_compositor;
  localparam int NL = 12;
  localparam int LW = NL * 30;
  localparam int FW = 8;
  localparam int FH = 4;
  localparam int FF = 8;

  typedef struct {
    int r; int g; int b;
    int px; int py; int top;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    px = '0;
  logic [9:0]    py = '0;
  logic [NL-1:0] layer_valid = '0;
  logic [LW-1:0] layer_rgb = '0;
  logic [NL-1:0] layer_en = '0;
  logic          over_valid = 1'b0;
  logic [29:0]   over_rgb = '0;
  logic          game_over = 1'b0;
  logic          hit_pulse = 1'b0;
  logic [9:0]    r;
  logic [9:0]    g;
  logic [9:0]    b;
  logic [9:0]    px_out;
  logic [9:0]    py_out;
  logic [3:0]    top_layer;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic cur_issue = 1'b0;
  logic [1:0] pipe;

  int   m_cnt = 0;
  bit   m_mode = 0;
  bit   m_prev = 0;

  vga_layer_compositor dut (
    .clk(clk), .reset(rst_n),
    .px(px), .py(py),
    .layer_valid(layer_valid),
    .layer_rgb(layer_rgb),
    .layer_en(layer_en),
    .over_valid(over_valid),
    .over_rgb(over_rgb),
    .game_over(game_over),
    .hit_pulse(hit_pulse),
    .r(r), .g(g), .b(b),
    .px_out(px_out), .py_out(py_out),
    .top_layer(top_layer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(
    input logic [9:0] x, input logic [9:0] y,
    input logic [NL-1:0] v, input logic [NL-1:0] en,
    input logic [LW-1:0] rgb,
    input logic ov, input logic [29:0] orgb);
    exp_t e;
    logic [29:0] c;
    int w;
    w = NL;
    c = 30'd0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (v[i] && en[i]) begin
        w = i;
        c = rgb[i*30 +: 30];
        break;
      end
    end
    if (m_mode) begin
      w = NL;
      c = ov ? orgb : 30'd0;
    end else if (m_cnt % 2 == 1) begin
      c = {10'h3FF, c[19:10] >> 1, c[9:0] >> 1};
    end
    e.r = int'(c[29:20]);
    e.g = int'(c[19:10]);
    e.b = int'(c[9:0]);
    e.px = int'(x);
    e.py = int'(y);
    e.top = w;
    return e;
  endfunction

  task automatic drive(
    input logic [9:0] x, input logic [9:0] y,
    input logic [NL-1:0] v, input logic [NL-1:0] en,
    input logic [LW-1:0] rgb,
    input logic ov, input logic [29:0] orgb,
    input logic go, input logic hit, input logic issue);
    bit org;
    bit sof;
    @(negedge clk);
    px = x; py = y;
    layer_valid = v; layer_en = en;
    layer_rgb = rgb;
    over_valid = ov; over_rgb = orgb;
    game_over = go; hit_pulse = hit;
    cur_issue = issue;
    org = (x == 0 && y == 0);
    sof = org && !m_prev;
    m_prev = org;
    if (hit) m_cnt = FF;
    else if (sof && m_cnt > 0) m_cnt--;
    if (sof) m_mode = go;
    if (issue) sb.push_back(model(x, y, v, en, rgb, ov, orgb));
  endtask

  task automatic run_frame(input int go_at, input logic go0,
                           input logic go1, input int hit_at,
                           input bit fixed);
    logic [NL-1:0] v;
    logic [NL-1:0] en;
    logic [LW-1:0] rgb;
    int idx;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        idx = y * FW + x;
        for (int i = 0; i < NL; i++) begin
          v[i]  = ($urandom_range(0, 2) == 0);
          en[i] = ($urandom_range(0, 5) != 0);
          rgb[i*30 +: 30] = 30'($urandom);
        end
        if (fixed) begin
          v = 12'h001;
          en = 12'hFFF;
          rgb[29:0] = {10'h100, 10'h100, 10'h100};
        end
        drive(10'(x), 10'(y), v, en, rgb,
              1'($urandom), 30'($urandom),
              (idx >= go_at) ? go1 : go0,
              1'(idx == hit_at), 1'b1);
        if (idx == hit_at && hit_at == 0) begin
          @(posedge clk);
          #1 chk("flash_cnt_collision", int'(dut.r_flash_cnt), FF);
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= 2'b00;
    else        pipe <= {pipe[0], cur_issue};
  end

  always @(negedge clk) begin
    if (pipe[1]) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty act=output exp=none t=%0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("r", int'(r), mon_e.r);
        chk("g", int'(g), mon_e.g);
        chk("b", int'(b), mon_e.b);
        chk("px_out", int'(px_out), mon_e.px);
        chk("py_out", int'(py_out), mon_e.py);
        chk("top_layer", int'(top_layer), mon_e.top);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_r"}, int'(r), 0);
    chk({tag, "_g"}, int'(g), 0);
    chk({tag, "_b"}, int'(b), 0);
    chk({tag, "_px"}, int'(px_out), 0);
    chk({tag, "_py"}, int'(py_out), 0);
    chk({tag, "_top"}, int'(top_layer), 0);
    chk({tag, "_cnt"}, int'(dut.r_flash_cnt), 0);
    chk({tag, "_mode"}, int'(dut.r_mode_go), 0);
  endtask

  initial begin
    logic [LW-1:0] rgb;
    bit done2;
    int hat;
    px = 10'd1;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NL; i++) rgb[i*30 +: 30] = 30'($urandom);
    drive(10'd3, 10'd1, 12'h224, 12'hFFF, rgb, 1'b0, 30'd0,
          1'b0, 1'b0, 1'b1);
    drive(10'd4, 10'd1, 12'h224, 12'hDFF, rgb, 1'b0, 30'd0,
          1'b0, 1'b0, 1'b1);
    drive(10'd5, 10'd2, 12'h000, 12'hFFF, rgb, 1'b1,
          30'h1234567, 1'b0, 1'b0, 1'b1);
    drive(10'd6, 10'd2, 12'h224, 12'h000, rgb, 1'b0, 30'd0,
          1'b0, 1'b0, 1'b1);

    run_frame(999, 1'b0, 1'b0, -1, 1'b0);
    run_frame(999, 1'b0, 1'b0, -1, 1'b0);

    done2 = 0;
    for (int f = 0; f < 16; f++) begin
      hat = -1;
      if (f == 0) hat = 5;
      else if (!done2 && m_cnt == 4) begin
        hat = 10;
        done2 = 1;
      end
      run_frame(999, 1'b0, 1'b0, hat, 1'b1);
    end

    run_frame(999, 1'b0, 1'b0, 5, 1'b0);
    run_frame(999, 1'b0, 1'b0, 0, 1'b0);

    run_frame(20, 1'b0, 1'b1, -1, 1'b0);
    run_frame(999, 1'b1, 1'b1, 7, 1'b0);
    run_frame(20, 1'b1, 1'b0, -1, 1'b0);
    run_frame(999, 1'b0, 1'b0, -1, 1'b1);
    run_frame(999, 1'b1, 1'b1, 3, 1'b0);

    drive(10'd0, 10'd0, 12'hFFF, 12'hFFF, rgb, 1'b1,
          30'h2AAAAAA, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++)
      drive(10'(i), 10'd0, 12'hFFF, 12'hFFF, rgb, 1'b1,
            30'h2AAAAAA, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      drive(10'd5, 10'd1, 12'hFFF, 12'hFFF, rgb, 1'b1,
            30'h2AAAAAA, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid");
    chk("sb_drained", sb.size(), 0);
    m_cnt = 0;
    m_mode = 0;
    m_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;

    drive(10'd2, 10'd3, 12'h010, 12'hFFF, rgb, 1'b1,
          30'h3FFFFFFF, 1'b0, 1'b0, 1'b1);
    run_frame(999, 1'b0, 1'b0, -1, 1'b0);

    for (int i = 0; i < 3; i++)
      drive(10'd7, 10'd3, 12'h000, 12'h000, rgb, 1'b0, 30'd0,
            1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sb_final_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Parametrised pixel compositor that sits between the per-object sprite printers and the VGA timing/DAC output. It resolves NUM_LAYERS layers by fixed priority through a two-stage registered pipeline. It adds frame-counted effects: a hit flash, and a game-over mode whose switch is latched at frame boundaries. It replaces hand-written per-object if-chains with one generic block.

## Interface
Parameters:
- NUM_LAYERS, 12, number of sprite layers; higher index has higher priority.
- COLOR_W, 10, bits per colour channel.
- POS_W, 10, width of px/py.
- FLASH_FRAMES, 8, frames a hit flash lasts (1..255).
- BG_R / BG_G / BG_B, 0, background colour when no layer is valid.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- px, py  in  POS_W each  current pixel coordinate.
- layer_valid  in  NUM_LAYERS  bit i set: layer i covers this pixel.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  layer i occupies bits [i*3*COLOR_W +: 3*COLOR_W], ordered {r,g,b}.
- layer_en  in  NUM_LAYERS  per-layer enable mask; a disabled layer is treated as not valid.
- over_valid  in  1  game-over overlay covers this pixel.
- over_rgb  in  3*COLOR_W  game-over overlay colour {r,g,b}.
- game_over  in  1  level; requests game-over mode.
- hit_pulse  in  1  one-cycle pulse; starts or restarts the hit flash.
- r, g, b  out  COLOR_W each  registered output colour.
- px_out, py_out  out  POS_W each  px/py delayed to align with r/g/b.
- top_layer  out  $clog2(NUM_LAYERS+1)  index of the winning layer; NUM_LAYERS means background or overlay.

## Operation
- Frame start (frame_sof): px==0 && py==0, with a registered detector so it is true for one cycle only.
- Mode register mode_go:
  - Loaded from game_over at frame_sof only.
  - A mid-frame change of game_over has no effect until the next frame.
- Stage 1, registered:
  - Priority resolve: winner is the highest i with layer_valid[i] & layer_en[i].
  - Latch the winner's colour and index; if there is no winner, latch the BG colour and index NUM_LAYERS.
  - Also latch over_valid, over_rgb, px and py.
- Stage 2, registered:
  - mode_go=1: output over_rgb if the stage-1 over_valid is set, else 0. top_layer = NUM_LAYERS. Flash is not applied.
  - mode_go=0: output the stage-1 colour with the flash applied.
- Flash counter flash_cnt, 8 bits:
  - hit_pulse loads FLASH_FRAMES, including while a flash is active (restart).
  - Decrements by 1 at each frame_sof while nonzero.
  - If hit_pulse and frame_sof occur in the same cycle, the load wins.
- Flash tint, applied while flash_cnt!=0 and flash_cnt[0]==1:
  - r = all ones.
  - g = g>>1, b = b>>1 (logical shift).
  - Because it depends on flash_cnt[0], the tint blinks on alternate frames.
- No arithmetic overflow is possible: the tint uses only saturation to the maximum and a right shift.

## Timing
- Latency is 2 clocks, from px/py/layer inputs to r/g/b/px_out/py_out/top_layer.
- The flash and mode state sampled in stage 2 is the value registered at that cycle's clock edge.
- Reset asserted, at any time, asynchronously clears:
  - r/g/b, px_out/py_out and top_layer → 0.
  - flash_cnt → 0, mode_go → 0.
  - Both pipeline stages → 0, and the frame_sof detector → 0.
- Reset is released synchronously by the system. The first valid output appears 2 clocks after the first sampled input.
- Layer enable mask: sampled every cycle, no latching.

## Structure
- A shared package `vga_pkg` holds:
  - COLOR_W and POS_W defaults.
  - An rgb struct/typedef.
  - The BG colour constant.
  - The FLASH_FRAMES default.
- One sub-module, `layer_priority_mux`: combinational, parametrised on NUM_LAYERS and COLOR_W. It outputs the winner index, colour and a hit flag. Stage 1 registers its outputs.
- Frame-start detection, mode_go, flash_cnt and stage 2 stay in the top module.

## Test plan
- Priority:
  - Drive NUM_LAYERS=12 with layers 2, 5 and 9 valid and all enabled → after 2 clocks the output equals layer 9's colour and top_layer=9.
  - Clear layer_en[9] → the output becomes layer 5's colour, top_layer=5.
- Background: no layer valid → r/g/b = BG, top_layer=12; px_out/py_out equal px/py delayed by 2.
- Flash:
  - Pulse hit_pulse with FLASH_FRAMES=8 and run 10 frames over a pixel whose colour is r/g/b=0x100 → tint (r=0x3FF, g=b=0x080) appears only in frames with odd flash_cnt (7,5,3,1).
  - The normal colour returns after 8 frames.
  - A second hit_pulse at count 3 reloads the count to 8.
- Mode latch:
  - Raise game_over mid-frame → output unchanged until the next frame_sof.
  - From then on: over_rgb where over_valid is set, 0 elsewhere, flash suppressed.
- Collision: assert hit_pulse in the same cycle as frame_sof → flash_cnt=FLASH_FRAMES, not FLASH_FRAMES-1.
- Reset mid-operation: assert reset during an active flash in game-over mode → all outputs are 0 immediately (asynchronous). After release, mode_go=0 and flash_cnt=0.
